// File: rtl/pipe_reg_chain.sv
// -----------------------------------------------------------------------------
// pipe_reg_chain
//   DEPTH-stage elastic pipeline register with a valid/ready handshake, a global
//   enable and a synchronous flush. Used between pipeline units that need
//   back-pressure (fetch->decode, decode->execute). A stall never drops or
//   duplicates an item, and a flush kills every in-flight entry.
//
// Parameters
//   W        data width per stage
//   DEPTH    number of register stages (>= 1)
//   RST_VAL  reset value of every stage data register
//
// Ports
//   clk        in   clock, all state on posedge
//   rst_n      in   synchronous active-low reset (wins over flush and en)
//   en         in   global enable; 0 freezes every stage and blocks handshakes
//   flush      in   synchronous kill of all in-flight entries
//   in_valid   in   upstream has data
//   in_ready   out  stage 0 can accept this cycle
//   in_data    in   upstream data
//   out_valid  out  last stage holds valid data
//   out_ready  in   downstream accepts
//   out_data   out  last stage data, forced to zero while flush is high
//   occ        out  number of valid stages (only with PIPE_REG_CHAIN_OCC_EN)
//
// Build option
//   PIPE_REG_CHAIN_OCC_EN  defined: adds the occ port and occupancy counter.
// -----------------------------------------------------------------------------
module pipe_reg_chain #(
  parameter int unsigned    W       = 32,
  parameter int unsigned    DEPTH   = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 out_data
`ifdef PIPE_REG_CHAIN_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   occ
`endif
);

  // Per-stage state: stage 0 faces upstream, stage DEPTH-1 drives the outputs.
  logic [DEPTH-1:0] r_v;
  logic [W-1:0]     r_d [DEPTH];

  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_src_v;
  logic [W-1:0]     w_src_d [DEPTH];
  logic             w_go;

  assign w_go = en & ~flush;

  // A stage can take new data when it is empty or everything downstream of it
  // can move. Written as "not all stages from here to the output are full, or
  // the output drains" so that no bit of w_rdy feeds another bit.
  always_comb begin : ready_chain
    logic w_tail_full;
    // NOTE: every variable of this block gets a value before any condition or
    // loop touches it, so no path leaves it unassigned and no latch is inferred.
    w_tail_full = 1'b1;
    w_rdy       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_tail_full = w_tail_full & r_v[i];
      w_rdy[i]    = ~w_tail_full | out_ready;
    end
  end

  // Source of each stage: upstream port for stage 0, previous stage otherwise.
  always_comb begin : source_mux
    w_src_v    = '0;
    w_src_d    = '{default: '0};
    w_src_v[0] = in_valid;
    w_src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_src_v[i] = r_v[i-1];
      w_src_d[i] = r_d[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v <= '0;
      // NOTE: the stage data registers are reset as well because out_data
      // exposes the last one directly after reset; they are plain flops, so a
      // reset value is legal here (a RAM-backed variant could not do this).
      for (int i = 0; i < DEPTH; i++) r_d[i] <= RST_VAL;
    end else if (flush) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) r_d[i] <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments make every stage sample its neighbour's
      // pre-edge value; blocking ones would ripple an item through several
      // stages in a single clock.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_rdy[i]) begin
          r_v[i] <= w_src_v[i];
          // An empty source leaves a bubble; the old data is simply ignored.
          if (w_src_v[i]) r_d[i] <= w_src_d[i];
        end
      end
    end
  end

  assign in_ready  = w_go & w_rdy[0];
  assign out_valid = w_go & r_v[DEPTH-1];
  assign out_data  = flush ? '0 : r_d[DEPTH-1];

`ifdef PIPE_REG_CHAIN_OCC_EN
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] r_occ;
  logic             w_push;
  logic             w_pop;

  // Both handshakes are already gated by en and flush, so the counter only
  // moves on real transfers and stays within 0..DEPTH.
  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
    end
  end

  assign occ = r_occ;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_reg_chain
//   Self-checking bench for pipe_reg_chain. Instance A (W=32, DEPTH=3,
//   RST_VAL=0xDEADBEEF) covers latency, back-pressure, flush, enable and reset.
//   Instance B (W=8, DEPTH=2) runs random valid/ready traffic. Accepted items
//   are pushed to a queue and popped/compared when the DUT hands them out.
//   occ is checked only when PIPE_REG_CHAIN_OCC_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipe_reg_chain;

  localparam int             W       = 32;
  localparam int             DEPTH   = 3;
  localparam logic [W-1:0]   RST_VAL = 32'hDEAD_BEEF;
  localparam int             BW      = 8;
  localparam int             BDEPTH  = 2;

  logic clk = 1'b0;
  logic rst_n;

  logic         en, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;

  logic          b_en, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [BW-1:0] b_in_data, b_out_data;

`ifdef PIPE_REG_CHAIN_OCC_EN
  localparam int OCC_W   = $clog2(DEPTH + 1);
  localparam int B_OCC_W = $clog2(BDEPTH + 1);
  logic [OCC_W-1:0]   occ;
  logic [B_OCC_W-1:0] b_occ;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0]  q  [$];
  logic [BW-1:0] bq [$];

  always #5 clk = ~clk;

  pipe_reg_chain #(.W(W), .DEPTH(DEPTH), .RST_VAL(RST_VAL)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef PIPE_REG_CHAIN_OCC_EN
    ,
    .occ      (occ)
`endif
  );

  pipe_reg_chain #(.W(BW), .DEPTH(BDEPTH), .RST_VAL('0)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (b_en),
    .flush    (b_flush),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .in_data  (b_in_data),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .out_data (b_out_data)
`ifdef PIPE_REG_CHAIN_OCC_EN
    ,
    .occ      (b_occ)
`endif
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop(output logic have, output logic [W-1:0] exp);
    have = (q.size() != 0);
    exp  = '0;
    if (have) exp = q.pop_front();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    b_en = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== RST_VAL) begin errors++; $display("FAIL rst_out_data: got %h expected %h", out_data, RST_VAL); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_b_out_valid: got %b expected 0", b_out_valid); end
    checks++; if (b_out_data !== 8'h00) begin errors++; $display("FAIL rst_b_out_data: got %h expected 00", b_out_data); end
`ifdef PIPE_REG_CHAIN_OCC_EN
    checks++; if (occ !== '0) begin errors++; $display("FAIL rst_occ: got %0d expected 0", occ); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  // Three back-to-back items into an empty pipe: each appears DEPTH cycles later.
  task automatic test_latency();
    logic [W-1:0] vals [3] = '{32'h11, 32'h22, 32'h33};
    logic [W-1:0] exp;
    logic         have;
    int           pops = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      in_valid = 1'b0;
      if (c < 3) begin in_valid = 1'b1; in_data = vals[c]; end
      @(negedge clk);
      checks++; if (out_valid !== (c >= DEPTH && c < DEPTH + 3)) begin errors++; $display("FAIL lat_valid: cycle %0d got %b", c, out_valid); end
      if (c < 3) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready: cycle %0d got %b expected 1", c, in_ready); end
      end
      if (out_valid && out_ready) begin
        sb_pop(have, exp); pops++;
        checks++; if (!have || out_data !== exp) begin errors++; $display("FAIL lat_data: got %h expected %h (queued=%b)", out_data, exp, have); end
      end
      if (in_valid && in_ready) q.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (pops != 3) begin errors++; $display("FAIL lat_count: got %0d items expected 3", pops); end
  endtask

  // Fill with the output stalled, release it for one cycle, then drain.
  task automatic test_backpressure();
    logic [W-1:0] vals [4] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    logic [5:0]   exp_rdy = 6'b010111;
    logic [W-1:0] exp;
    logic         have;
    int           n = 0;
    int           pops = 0;
    for (int c = 0; c < 14; c++) begin
      in_valid  = (n < 4);
      if (n < 4) in_data = vals[n];
      out_ready = (c == 4) || (c >= 6);
      @(negedge clk);
      if (c < 6) begin
        checks++; if (in_ready !== exp_rdy[c]) begin errors++; $display("FAIL bp_in_ready: cycle %0d got %b expected %b", c, in_ready, exp_rdy[c]); end
      end
      if (c >= 3 && c < 6) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: cycle %0d got %b expected 1", c, out_valid); end
      end
      if (c == 3) begin
        checks++; if (out_data !== 32'hA1) begin errors++; $display("FAIL bp_head: got %h expected a1", out_data); end
`ifdef PIPE_REG_CHAIN_OCC_EN
        checks++; if (occ !== OCC_W'(3)) begin errors++; $display("FAIL bp_occ: got %0d expected 3", occ); end
`endif
      end
      if (out_valid && out_ready) begin
        sb_pop(have, exp); pops++;
        checks++; if (!have || out_data !== exp) begin errors++; $display("FAIL bp_data: got %h expected %h (queued=%b)", out_data, exp, have); end
      end
      if (in_valid && in_ready) begin q.push_back(in_data); n++; end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (pops != 4) begin errors++; $display("FAIL bp_count: got %0d items expected 4", pops); end
  endtask

  // Flush a full pipe while an item is offered; only the post-flush item emerges.
  task automatic test_flush();
    logic [W-1:0] exp;
    logic         have;
    int           pops = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = 32'hB0 + c;
      @(negedge clk);
      if (in_valid && in_ready) q.push_back(in_data);
      tick();
    end
    in_valid = 1'b1; in_data = 32'hBAD; flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL fl_out_data: got %h expected 0", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_in_ready: got %b expected 0", in_ready); end
    tick();
    q.delete();
    flush = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c == 0); in_data = 32'hC1;
      @(negedge clk);
      if (c == 0) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_post_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL fl_post_data: got %h expected 0", out_data); end
`ifdef PIPE_REG_CHAIN_OCC_EN
        checks++; if (occ !== '0) begin errors++; $display("FAIL fl_post_occ: got %0d expected 0", occ); end
`endif
      end
      checks++; if (out_valid !== (c == DEPTH)) begin errors++; $display("FAIL fl_post_valid: cycle %0d got %b", c, out_valid); end
      if (out_valid && out_ready) begin
        sb_pop(have, exp); pops++;
        checks++; if (!have || out_data !== exp) begin errors++; $display("FAIL fl_data: got %h expected %h (queued=%b)", out_data, exp, have); end
      end
      if (in_valid && in_ready) q.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (pops != 1) begin errors++; $display("FAIL fl_count: got %0d items expected 1", pops); end
  endtask

  // Streaming with en low for 4 cycles mid-stream; sequence must resume intact.
  task automatic test_enable();
    logic [W-1:0] exp;
    logic         have;
    int           n = 0;
    int           pops = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      en       = !(c >= 5 && c < 9);
      in_valid = (n < 8);
      if (n < 8) in_data = 32'h100 + n;
      @(negedge clk);
      if (!en) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL en_in_ready: cycle %0d got %b expected 0", c, in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL en_out_valid: cycle %0d got %b expected 0", c, out_valid); end
      end
      if (out_valid && out_ready) begin
        sb_pop(have, exp); pops++;
        checks++; if (!have || out_data !== exp) begin errors++; $display("FAIL en_data: got %h expected %h (queued=%b)", out_data, exp, have); end
      end
      if (in_valid && in_ready) begin q.push_back(in_data); n++; end
      tick();
    end
    en = 1'b1; in_valid = 1'b0;
    checks++; if (pops != 8) begin errors++; $display("FAIL en_count: got %0d items expected 8", pops); end
  endtask

  // Reset a full pipe; it must look exactly like power-on reset.
  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = 32'hD0 + c;
      @(negedge clk);
      if (in_valid && in_ready) q.push_back(in_data);
      tick();
    end
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q.delete();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== RST_VAL) begin errors++; $display("FAIL rm_out_data: got %h expected %h", out_data, RST_VAL); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready: got %b expected 1", in_ready); end
`ifdef PIPE_REG_CHAIN_OCC_EN
    checks++; if (occ !== '0) begin errors++; $display("FAIL rm_occ: got %0d expected 0", occ); end
`endif
    tick();
    out_ready = 1'b1;
  endtask

  // Random valid/ready on the DEPTH=2 instance against the scoreboard.
  task automatic test_random();
    logic [BW-1:0] exp;
    logic          pending = 1'b0;
    for (int c = 0; c < 1008; c++) begin
      if (c >= 1000) begin
        b_in_valid = 1'b0; b_out_ready = 1'b1;
      end else begin
        if (!pending) begin
          b_in_valid = 1'($urandom_range(0, 1));
          b_in_data  = BW'($urandom);
        end
        b_out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      checks++; if (b_in_ready !== (bq.size() < BDEPTH || b_out_ready)) begin errors++; $display("FAIL rnd_in_ready: cycle %0d got %b (held=%0d out_ready=%b)", c, b_in_ready, bq.size(), b_out_ready); end
`ifdef PIPE_REG_CHAIN_OCC_EN
      checks++; if (b_occ !== B_OCC_W'(bq.size()) || b_occ > BDEPTH) begin errors++; $display("FAIL rnd_occ: cycle %0d got %0d expected %0d", c, b_occ, bq.size()); end
`endif
      if (b_out_valid && b_out_ready) begin
        checks++;
        if (bq.size() == 0) begin
          errors++; $display("FAIL rnd_data: got %h with nothing outstanding", b_out_data);
        end else begin
          exp = bq.pop_front();
          if (b_out_data !== exp) begin errors++; $display("FAIL rnd_data: cycle %0d got %h expected %h", c, b_out_data, exp); end
        end
      end
      if (b_in_valid && b_in_ready) bq.push_back(b_in_data);
      pending = b_in_valid && !b_in_ready;
      tick();
    end
    checks++; if (bq.size() != 0) begin errors++; $display("FAIL rnd_drain: %0d items never emerged, expected 0", bq.size()); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_flush();
    test_enable();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
